// File: rtl/uart_cmd_decoder.sv
// Byte-stream command decoder: turns UART frames (opcode, addr_hi, addr_lo, len, data)
// into SPC700 RAM write/read strobes and returns an ACK or the read bytes to the transmitter.
module uart_cmd_decoder #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter logic [7:0]  ACK_BYTE       = 8'h06
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  tx_byte,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        busy,
  output logic        err
);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    LEN,
    WDATA,
    RD_REQ,
    RD_CAP,
    TX_REQ,
    TX_WAIT
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [15:0] r_addr;
  logic [15:0] r_memAddr;
  logic [15:0] r_timer;
  logic [7:0]  r_memWdata;
  logic [7:0]  r_txByte;
  logic [8:0]  r_count;
  logic        r_isWrite;
  logic        r_memWe;
  logic        r_err;
  logic        r_txWaitFirst;
  logic        w_inFrame;
  logic        w_timeout;
  logic        w_badOp;
  logic [8:0]  w_lenVal;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A received byte always beats the inter-byte timeout in the same cycle.
  always_comb begin
    w_nextState = r_state;
    w_badOp     = 1'b0;
    w_inFrame   = (r_state == ADDR_HI) || (r_state == ADDR_LO) ||
                  (r_state == LEN)     || (r_state == WDATA);
    w_timeout   = w_inFrame && !rx_valid && (r_timer >= TIMEOUT_CYCLES);
    w_lenVal    = (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
    case (r_state)
      IDLE: begin
        if (rx_valid) begin
          if ((rx_byte == OP_WRITE) || (rx_byte == OP_READ)) begin
            w_nextState = ADDR_HI;
          end else begin
            w_badOp = 1'b1;
          end
        end
      end
      ADDR_HI: if (rx_valid) w_nextState = ADDR_LO;
      ADDR_LO: if (rx_valid) w_nextState = LEN;
      LEN:     if (rx_valid) w_nextState = r_isWrite ? WDATA : RD_REQ;
      WDATA:   if (rx_valid && (r_count == 9'd1)) w_nextState = TX_REQ;
      RD_REQ:  w_nextState = RD_CAP;
      RD_CAP:  w_nextState = TX_REQ;
      TX_REQ:  if (!tx_busy) w_nextState = TX_WAIT;
      TX_WAIT: begin
        if (!r_txWaitFirst && !tx_busy) begin
          w_nextState = (r_count != 9'd0) ? RD_REQ : IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
    if (w_timeout) begin
      w_nextState = IDLE;
    end
  end

  // mem_addr is loaded only when a strobe is issued, so it holds between accesses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr        <= 16'h0000;
      r_memAddr     <= 16'h0000;
      r_timer       <= 16'h0000;
      r_memWdata    <= 8'h00;
      r_txByte      <= 8'h00;
      r_count       <= 9'd0;
      r_isWrite     <= 1'b0;
      r_memWe       <= 1'b0;
      r_err         <= 1'b0;
      r_txWaitFirst <= 1'b0;
    end else begin
      r_memWe <= 1'b0;
      r_err   <= w_badOp || w_timeout;
      if (!w_inFrame || rx_valid) begin
        r_timer <= 16'h0000;
      end else if (r_timer != 16'hFFFF) begin
        r_timer <= r_timer + 16'd1;
      end
      case (r_state)
        IDLE: begin
          if (rx_valid) r_isWrite <= (rx_byte == OP_WRITE);
        end
        ADDR_HI: begin
          if (rx_valid) r_addr[15:8] <= rx_byte;
        end
        ADDR_LO: begin
          if (rx_valid) r_addr[7:0] <= rx_byte;
        end
        LEN: begin
          if (rx_valid) begin
            if (r_isWrite) begin
              r_count <= w_lenVal;
            end else begin
              r_count   <= w_lenVal - 9'd1;
              r_memAddr <= r_addr;
              r_addr    <= r_addr + 16'd1;
            end
          end
        end
        WDATA: begin
          if (rx_valid) begin
            r_memWe    <= 1'b1;
            r_memAddr  <= r_addr;
            r_memWdata <= rx_byte;
            r_addr     <= r_addr + 16'd1;
            r_count    <= r_count - 9'd1;
            if (r_count == 9'd1) r_txByte <= ACK_BYTE;
          end
        end
        RD_CAP: begin
          r_txByte <= mem_rdata;
        end
        TX_REQ: begin
          if (!tx_busy) r_txWaitFirst <= 1'b1;
        end
        TX_WAIT: begin
          r_txWaitFirst <= 1'b0;
          if (!r_txWaitFirst && !tx_busy && (r_count != 9'd0)) begin
            r_count   <= r_count - 9'd1;
            r_memAddr <= r_addr;
            r_addr    <= r_addr + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign mem_we    = r_memWe;
  assign mem_re    = (r_state == RD_REQ);
  assign tx_byte   = r_txByte;
  assign tx_start  = (r_state == TX_REQ) && !tx_busy;
  assign busy      = (r_state != IDLE);
  assign err       = r_err;

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd50000: idle cycles tolerated between bytes of one frame.
REQ-002 SHALL have parameter ACK_BYTE, default 8'h06: byte transmitted on write-frame completion.
REQ-003 SHALL have port clock  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_byte  in  8  received byte from UART receiver.
REQ-006 SHALL have port rx_valid  in  1  one-cycle pulse; rx_byte valid that cycle.
REQ-007 SHALL have port mem_addr  out  16  SPC700 RAM address.
REQ-008 SHALL have port mem_wdata  out  8  RAM write data.
REQ-009 SHALL have port mem_we  out  1  one-cycle write strobe.
REQ-010 SHALL have port mem_re  out  1  one-cycle read strobe.
REQ-011 SHALL have port mem_rdata  in  8  read data, valid the cycle after mem_re.
REQ-012 SHALL have port tx_byte  out  8  byte for UART transmitter.
REQ-013 SHALL have port tx_start  out  1  one-cycle transmit request.
REQ-014 SHALL have port tx_busy  in  1  transmitter busy.
REQ-015 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-016 SHALL have port err  out  1  one-cycle pulse on bad opcode or timeout.

Function
REQ-017 Frame format SHALL be: opcode, addr_hi, addr_lo, len, then len data bytes for write only; len 0 means 256.
REQ-018 Opcode 8'h57 ('W') SHALL select write; 8'h52 ('R') SHALL select read; any other opcode in IDLE SHALL pulse err and stay IDLE.
REQ-019 States SHALL be IDLE, ADDR_HI, ADDR_LO, LEN, WDATA, RD_REQ, RD_CAP, TX_REQ, TX_WAIT.
REQ-020 On each rx_valid in WDATA, mem_we SHALL pulse the next cycle with mem_addr = current address and mem_wdata = rx_byte.
REQ-021 Address SHALL increment by 1 after each access, wrapping 16'hFFFF -> 16'h0000; remaining count SHALL be 9 bits.
REQ-022 After the last write byte, the block SHALL enter TX_REQ and send ACK_BYTE, then return to IDLE.
REQ-023 Read sequence per byte: RD_REQ pulses mem_re one cycle; RD_CAP latches mem_rdata into tx_byte; TX_REQ waits for tx_busy=0, then pulses tx_start one cycle.
REQ-024 TX_WAIT SHALL wait one cycle, then until tx_busy=0; it SHALL then go to RD_REQ if bytes remain, else IDLE.
REQ-025 rx_valid in RD_REQ, RD_CAP, TX_REQ or TX_WAIT SHALL be ignored.
REQ-026 In ADDR_HI, ADDR_LO, LEN and WDATA, a counter SHALL clear on rx_valid; when it reaches TIMEOUT_CYCLES, the block SHALL pulse err and go to IDLE with no memory strobe.
REQ-027 mem_we and mem_re SHALL never be high in the same cycle; tx_start SHALL never assert while tx_busy=1.
REQ-028 mem_wdata, mem_addr and tx_byte SHALL hold their values between strobes.

Reset
REQ-029 reset_n=0 SHALL immediately force: state IDLE; mem_we, mem_re, tx_start, err, busy = 0; mem_addr = 16'h0000; mem_wdata, tx_byte = 8'h00; counters = 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; the first byte after release SHALL be decoded as an opcode.

Verification
REQ-031 Bytes 57 12 34 02 AA BB -> mem_we twice: (1234, AA), (1235, BB); then tx_start once with tx_byte 06; busy low afterwards.
REQ-032 Bytes 52 FF FF 02, RAM[FFFF]=5A, RAM[0000]=C3, tx_busy held 20 cycles per byte -> mem_re at FFFF then 0000; tx bytes 5A, C3; tx_start only when tx_busy=0.
REQ-033 Byte 41 in IDLE -> err pulses one cycle; no strobes; next byte 57 starts a write frame.
REQ-034 Bytes 57 00 10, then silence for TIMEOUT_CYCLES (set to 100) -> err pulses, state IDLE, no mem_we.
REQ-035 Write frame with len 00 -> exactly 256 mem_we pulses, then ACK; reset_n pulsed low after byte 3 of a second frame -> all outputs zero immediately, no further strobes.
